muldiv_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide controller for the MIPS32 EX stage. It services MULTU and DIVU by time-sharing the combinational 32-bit ALU: it drives the ALU operands and control code, reads back the ALU result, and keeps the HI/LO state itself. The pipeline hazard unit stalls on `busy` and reads `hi`/`lo` after `done`.

---
 rtl/muldiv_sequencer_if.sv | 14 +
 rtl/muldiv_sequencer.sv | 65 ++++++
 tb/tb_muldiv_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the EX-stage hazard logic and the mul/div sequencer
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo, div_zero);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-cycle unsigned MULTU/DIVU controller time-sharing the EX-stage ALU
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_out
);
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] hi, lo, m, r;
  logic             op_r, div_zero, run, zero, c, ge;
  assign bus.busy     = run;
  assign bus.done     = state == DONE;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.div_zero = div_zero;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // next state, ALU drive and the carry/compare bits recovered from the 32-bit ALU result
  always_comb begin
    run      = state == RUN;
    zero     = bus.op && bus.rt_val == '0;
    r        = {hi[WIDTH-2:0], lo[WIDTH-1]};
    state_n  = state == IDLE ? (bus.start ? (zero ? DONE : RUN) : IDLE)
             : state == RUN  ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
    alu_a    = run ? (op_r ? r : hi) : '0;
    alu_b    = run ? m : '0;
    alu_ctrl = run && op_r ? ALU_SUB : ALU_ADD;
    c        = (hi[WIDTH-1] & m[WIDTH-1]) | ((hi[WIDTH-1] | m[WIDTH-1]) & ~alu_out[WIDTH-1]);
    ge       = hi[WIDTH-1] | (r[WIDTH-1] & ~m[WIDTH-1]) | (~(r[WIDTH-1] ^ m[WIDTH-1]) & ~alu_out[WIDTH-1]);
  end
  // operand latch on accept, then one shift-add or restoring-subtract step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      op_r     <= 1'b0;
      cnt      <= '0;
      div_zero <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      hi       <= zero ? bus.rs_val : '0;
      lo       <= zero ? '1 : bus.op ? bus.rs_val : bus.rt_val;
      m        <= bus.op ? bus.rt_val : bus.rs_val;
      op_r     <= bus.op;
      cnt      <= '0;
      div_zero <= zero;
    end else if (run) begin
      cnt      <= cnt + 5'd1;
      {hi, lo} <= op_r ? {ge ? alu_out : r, lo[WIDTH-2:0], ge}
                       : {lo[0] ? {c, alu_out} : {1'b0, hi}, lo[WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench with an arithmetic reference model and an external ALU model
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  assign alu_out = alu_ctrl == 4'b1001 ? alu_a - alu_b : alu_ctrl == 4'b1000 ? alu_a + alu_b : 32'h0;
  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
    int          busy_n;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b, input int now);
    exp_t x;
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    x.dz = 1'b0; x.busy_n = 32; x.done_cyc = now + 33;
    if (!op) begin
      x.hi = p[63:32]; x.lo = p[31:0];
    end else if (b == 32'h0) begin
      x.hi = a; x.lo = 32'hFFFFFFFF; x.dz = 1'b1; x.busy_n = 0; x.done_cyc = now + 1;
    end else begin
      x.hi = a % b; x.lo = a / b;
    end
    return x;
  endfunction
  // monitor: compares every done pulse against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst) busy_n = 0;
    else begin
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) check("busy_done_overlap", 1, 0);
      if (bus.done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check("hi", bus.hi, e.hi);
          check("lo", bus.lo, e.lo);
          check("div_zero", bus.div_zero, e.dz);
          check("done_latency", cyc, e.done_cyc);
          check("busy_cycles", busy_n, e.busy_n);
        end
        busy_n = 0;
      end
    end
  end
  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    if (push) q.push_back(model(op, a, b, cyc));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.op = $urandom_range(0, 1); bus.rs_val = $urandom; bus.rt_val = $urandom;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout_pending", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_div_zero"}, bus.div_zero, 0);
    check({tag, "_hi"}, bus.hi, 0);
    check({tag, "_lo"}, bus.lo, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctrl"}, alu_ctrl, 4'b1000);
  endtask
  logic [64:0] dir [10] = '{
    {1'b0, 32'd7, 32'd6},
    {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF},
    {1'b0, 32'h80000000, 32'd2},
    {1'b1, 32'd100, 32'd7},
    {1'b1, 32'd5, 32'd9},
    {1'b1, 32'hFFFFFFFF, 32'h80000000},
    {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE},
    {1'b1, 32'h1234, 32'h0},
    {1'b0, 32'd3, 32'd3},
    {1'b1, 32'd0, 32'd1}
  };
  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.rs_val = '0; bus.rt_val = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle_after_reset");
    for (int i = 0; i < 10; i++) begin
      send(dir[i][64], dir[i][63:32], dir[i][31:0], 1'b1);
      drain();
      if (i == 7) check("div_zero_held", bus.div_zero, 1);
    end
    send(1'b0, 32'd12345, 32'd678, 1'b1);
    repeat (9) @(negedge clk);
    send(1'b1, 32'd99, 32'd0, 1'b0);
    drain();
    send(1'b1, 32'hDEADBEEF, 32'd1000, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_run_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(1'b0, 32'd2, 32'd3, 1'b1);
    drain();
    for (int i = 0; i < 40; i++) begin
      logic op;
      logic [31:0] a, b;
      op = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      send(op, a, b, 1'b1);
      drain();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
